// File: rtl/subneg_prog_loader.sv
// Program loader for the SUBNEG core: synchronises a slow asynchronous word/strobe/mode
// interface, checks length and checksum framing, and writes the image into core memory.
module subneg_prog_loader #(
    parameter int WORD_W = 5,
    parameter int DEPTH  = 22,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_mode,
    input  logic              in_strobe,
    input  logic [WORD_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              run,
    output logic              busy,
    output logic [1:0]        error
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic              m1, m2, m3, s1, s2, s3;
    logic [WORD_W-1:0] d1, d2;
    logic [WORD_W-1:0] len, len_nx, sum, sum_nx, mem_wdata_nx;
    logic [ADDR_W-1:0] addr, addr_nx, mem_addr_nx;
    logic              mem_we_nx;
    logic [1:0]        error_nx;
    logic              rise, mode_rise;

    assign rise      = s2 & ~s3;
    assign mode_rise = m2 & ~m3;
    assign run       = (state == DONE);
    assign busy      = (state == HDR) || (state == DATA) || (state == CSUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {m1, m2, m3, s1, s2, s3} <= '0;
            d1        <= '0;
            d2        <= '0;
            state     <= IDLE;
            len       <= '0;
            sum       <= '0;
            addr      <= '0;
            error     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            {m1, m2, m3} <= {in_mode, m1, m2};
            {s1, s2, s3} <= {in_strobe, s1, s2};
            d1        <= in_data;
            d2        <= d1;
            state     <= state_nx;
            len       <= len_nx;
            sum       <= sum_nx;
            addr      <= addr_nx;
            error     <= error_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        len_nx       = len;
        sum_nx       = sum;
        addr_nx      = addr;
        error_nx     = error;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        case (state)
            IDLE, DONE, ERR: begin
                // Strobes are ignored here; only a fresh mode rise starts a load.
                if (mode_rise) begin
                    state_nx = HDR;
                    error_nx = 2'd0;
                    sum_nx   = '0;
                    addr_nx  = '0;
                end
            end
            HDR, DATA, CSUM: begin
                // Losing mode beats a same-cycle strobe: that word is dropped.
                if (!m2) begin
                    state_nx = ERR;
                    error_nx = 2'd3;
                end else if (rise) begin
                    if (state == HDR) begin
                        len_nx = d2;
                        if (d2 == '0 || 32'(d2) > DEPTH) begin
                            state_nx = ERR;
                            error_nx = 2'd1;
                        end else begin
                            state_nx = DATA;
                        end
                    end else if (state == DATA) begin
                        mem_we_nx    = 1'b1;
                        mem_addr_nx  = addr;
                        mem_wdata_nx = d2;
                        sum_nx       = sum + d2;
                        addr_nx      = addr + ADDR_W'(1);
                        if (32'(addr) == 32'(len) - 32'd1)
                            state_nx = CSUM;
                    end else begin
                        if (d2 == sum) begin
                            state_nx = DONE;
                        end else begin
                            state_nx = ERR;
                            error_nx = 2'd2;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
